// File: rtl/axi_lite_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_seq_pkg
// Brief    : Shared types and constants for the AXI4-Lite sequential master.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        FINISH  = 3'd5
    } seq_state_t;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    localparam int c_err_cnt_w = 8;
    localparam logic [c_err_cnt_w-1:0] c_err_cnt_max = '1;

endpackage
`default_nettype wire

// File: rtl/axi_lite_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_seq_checker
// Brief    : Response/data compare with a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_seq_checker
    import axi_lite_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_valid,
    input  logic                   i_check_data,
    input  logic [1:0]             i_resp,
    input  logic [DATA_W-1:0]      i_actual,
    input  logic [DATA_W-1:0]      i_expected,
    output logic [c_err_cnt_w-1:0] o_err_count,
    output logic                   o_error
);

    logic                   w_mismatch;
    logic [c_err_cnt_w-1:0] r_err_count;

    // A bad response and a bad data word on the same beat count as one error.
    assign w_mismatch = (i_resp != c_resp_okay) ||
                        (i_check_data && (i_actual != i_expected));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (i_clear) begin
            r_err_count <= '0;
        end else if (i_valid && w_mismatch && (r_err_count != c_err_cnt_max)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_err_count = r_err_count;
    assign o_error     = (r_err_count != '0);

endmodule
`default_nettype wire

// File: rtl/axi_lite_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_seq_master
// Brief    : Writes an incrementing pattern over AXI4-Lite, reads it back and
//            counts mismatches and error responses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_seq_master
    import axi_lite_seq_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_WORDS        = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_START_VALUE      = 32'h0000_0001
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [c_err_cnt_w-1:0]          err_count,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    // Index is 8 bits wide to cover the full 1..256 word range.
    localparam logic [7:0] c_last_idx = 8'(C_NUM_WORDS - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic [7:0] r_index;
    logic [7:0] w_index_nxt;
    logic       r_aw_done;
    logic       w_aw_done_nxt;
    logic       r_w_done;
    logic       w_w_done_nxt;

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_last;
    logic       w_clear;
    logic       w_chk_valid;
    logic       w_chk_data;
    logic [1:0] w_chk_resp;

    logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] w_data;

    assign w_addr = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({r_index, 2'b00});
    assign w_data = C_START_VALUE + C_M_AXI_DATA_WIDTH'(r_index);
    assign w_last = (r_index == c_last_idx);

    // Each write channel drops its VALID on its own once accepted.
    assign M_AXI_AWVALID = (r_state == WR_REQ) && !r_aw_done;
    assign M_AXI_WVALID  = (r_state == WR_REQ) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == WR_RESP);
    assign M_AXI_ARVALID = (r_state == RD_REQ);
    assign M_AXI_RREADY  = (r_state == RD_RESP);

    // Address/data are zeroed outside their request phase so reset forces them low.
    assign M_AXI_AWADDR  = M_AXI_AWVALID ? w_addr : '0;
    assign M_AXI_WDATA   = M_AXI_WVALID  ? w_data : '0;
    assign M_AXI_ARADDR  = M_AXI_ARVALID ? w_addr : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;

    assign busy = (r_state != IDLE);
    assign done = (r_state == FINISH);

    assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID  && M_AXI_WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_clear       = 1'b0;
        w_chk_valid   = 1'b0;
        w_chk_data    = 1'b0;
        w_chk_resp    = c_resp_okay;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear       = 1'b1;
                    w_index_nxt   = '0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = WR_REQ;
                end
            end

            WR_REQ: begin
                if (w_aw_hs) w_aw_done_nxt = 1'b1;
                if (w_w_hs)  w_w_done_nxt  = 1'b1;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = WR_RESP;
                end
            end

            WR_RESP: begin
                w_chk_resp = M_AXI_BRESP;
                if (M_AXI_BVALID) begin
                    w_chk_valid = 1'b1;
                    if (w_last) begin
                        w_index_nxt = '0;
                        w_state_nxt = RD_REQ;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                        w_state_nxt = WR_REQ;
                    end
                end
            end

            RD_REQ: begin
                if (M_AXI_ARREADY) w_state_nxt = RD_RESP;
            end

            RD_RESP: begin
                w_chk_resp = M_AXI_RRESP;
                w_chk_data = 1'b1;
                if (M_AXI_RVALID) begin
                    w_chk_valid = 1'b1;
                    if (w_last) begin
                        w_index_nxt = '0;
                        w_state_nxt = FINISH;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                        w_state_nxt = RD_REQ;
                    end
                end
            end

            FINISH: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    axi_lite_seq_checker #(
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_checker (
        .clk          (ACLK),
        .rst          (ARESET),
        .i_clear      (w_clear),
        .i_valid      (w_chk_valid),
        .i_check_data (w_chk_data),
        .i_resp       (w_chk_resp),
        .i_actual     (M_AXI_RDATA),
        .i_expected   (w_data),
        .o_err_count  (err_count),
        .o_error      (error)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_seq_master
// Brief    : Scoreboarded bench with a reactive AXI4-Lite memory slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_seq_master;
    import axi_lite_seq_pkg::*;

    localparam int          N       = 4;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam logic [31:0] START_V = 32'h0000_0001;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    logic start  = 1'b0;
    logic busy, done, error;
    logic [7:0]  err_count;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axi_lite_seq_master dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_count     (err_count),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave configuration and scoreboard
    int  aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit  corrupt_8 = 0, bresp_err = 0, rresp_err = 0;
    logic [31:0] mem [0:63];
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int  proto_viol = 0;

    bit  aw_got, w_got, ar_got, b_hs, r_hs;
    bit  awv_pend, wv_pend, arv_pend;
    int  aw_cnt, w_cnt, ar_cnt;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;

    // Ready/valid decisions are made at negedge; handshakes land on the next posedge.
    initial begin : slave
        logic [63:0] e;
        logic [31:0] ea;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                awv_pend = 0; wv_pend = 0; arv_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; ar_addr_l = 32'hFFFF_FFFF;
            end else begin
                if (awv_pend && !M_AXI_AWVALID) proto_viol++;
                if (wv_pend  && !M_AXI_WVALID)  proto_viol++;
                if (arv_pend && !M_AXI_ARVALID) proto_viol++;
                if (b_hs) begin M_AXI_BVALID = 0; M_AXI_BRESP = 0; b_hs = 0; end
                if (r_hs) begin M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; r_hs = 0; end
                if (M_AXI_AWVALID && aw_got) proto_viol++;
                if (M_AXI_WVALID && w_got)   proto_viol++;
                if (M_AXI_ARVALID && (aw_got || w_got || M_AXI_BVALID)) proto_viol++;
                if ((M_AXI_AWVALID || M_AXI_WVALID) && (ar_got || M_AXI_RVALID)) proto_viol++;

                if (aw_got && w_got && !M_AXI_BVALID) begin
                    if (exp_wr_q.size() == 0) begin
                        check_eq("wr_extra", aw_addr_l, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check_eq("wr_addr", aw_addr_l, e[63:32]);
                        check_eq("wr_data", w_data_l, e[31:0]);
                    end
                    mem[aw_addr_l[7:2]] = w_data_l;
                    M_AXI_BVALID = 1;
                    M_AXI_BRESP  = bresp_err ? c_resp_slverr : c_resp_okay;
                    aw_got = 0; w_got = 0;
                end
                if (ar_got && !M_AXI_RVALID) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = (corrupt_8 && ar_addr_l == 32'h8) ? 32'h0000_DEAD : mem[ar_addr_l[7:2]];
                    M_AXI_RRESP  = rresp_err ? c_resp_slverr : c_resp_okay;
                    ar_got = 0;
                end

                M_AXI_AWREADY = 0;
                if (M_AXI_AWVALID && !aw_got) begin
                    if (aw_cnt >= aw_delay) M_AXI_AWREADY = 1; else aw_cnt++;
                end
                M_AXI_WREADY = 0;
                if (M_AXI_WVALID && !w_got) begin
                    if (w_cnt >= w_delay) M_AXI_WREADY = 1; else w_cnt++;
                end
                M_AXI_ARREADY = 0;
                if (M_AXI_ARVALID && !ar_got && !M_AXI_RVALID) begin
                    if (ar_cnt >= ar_delay) M_AXI_ARREADY = 1; else ar_cnt++;
                end

                if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_got = 1; aw_addr_l = M_AXI_AWADDR; aw_cnt = 0; end
                if (M_AXI_WVALID && M_AXI_WREADY)   begin w_got = 1;  w_data_l = M_AXI_WDATA;   w_cnt = 0;  end
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    ar_got = 1; ar_addr_l = M_AXI_ARADDR; ar_cnt = 0;
                    if (exp_rd_q.size() == 0) begin
                        check_eq("rd_extra", ar_addr_l, 32'hFFFF_FFFF);
                    end else begin
                        ea = exp_rd_q.pop_front();
                        check_eq("rd_addr", ar_addr_l, ea);
                    end
                end
                awv_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
                wv_pend  = M_AXI_WVALID  && !M_AXI_WREADY;
                arv_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
                b_hs = M_AXI_BVALID && M_AXI_BREADY;
                r_hs = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    task automatic push_pass();
        for (int i = 0; i < N; i++) begin
            exp_wr_q.push_back({BASE + 32'(4 * i), START_V + 32'(i)});
            exp_rd_q.push_back(BASE + 32'(4 * i));
        end
    endtask

    task automatic run_pass(input string name, input int exp_lat, input int exp_err);
        int lat;
        bit seen;
        push_pass();
        @(negedge ACLK);
        start = 1;
        lat = 1;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(posedge ACLK);
            #1;
            start = 0;
            lat++;
            if (c == 0) check_eq({name, "_clear"}, 32'(err_count), 32'd0);
            if (done) seen = 1;
        end
        check_eq({name, "_done"}, 32'(seen), 32'd1);
        if (exp_lat != 0) check_eq({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({name, "_err_count"}, 32'(err_count), 32'(exp_err));
        check_eq({name, "_error"}, 32'(error), 32'(exp_err != 0));
        check_eq({name, "_sb_empty"}, 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);
        @(posedge ACLK);
        #1;
        check_eq({name, "_idle"}, 32'({busy, done}), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_ctrl"}, 32'({busy, done, error}), 32'd0);
        check_eq({name, "_err_count"}, 32'(err_count), 32'd0);
        check_eq({name, "_vr"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                     M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check_eq({name, "_awaddr"}, M_AXI_AWADDR, 32'd0);
        check_eq({name, "_wdata"}, M_AXI_WDATA, 32'd0);
        check_eq({name, "_araddr"}, M_AXI_ARADDR, 32'd0);
    endtask

    initial begin : main
        int  cyc, dones, d1, d2, busy_cnt;
        bit  hit;
        repeat (3) @(posedge ACLK);
        #1;
        check_all_zero("reset");
        check_eq("prot_strb", 32'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 32'h00F);
        @(negedge ACLK);
        #2 ARESET = 0;

        run_pass("base", 4 * N + 2, 0);
        check_eq("mem_word2", mem[2], START_V + 32'd2);

        aw_delay = 3;
        run_pass("aw_late", 0, 0);
        aw_delay = 0; w_delay = 2;
        run_pass("w_late", 0, 0);
        w_delay = 0;

        corrupt_8 = 1;
        run_pass("corrupt", 0, 1);
        corrupt_8 = 0;

        bresp_err = 1; rresp_err = 1;
        run_pass("slverr", 0, 8);
        bresp_err = 0; rresp_err = 0;

        // Abort during the read response of word 2
        push_pass();
        @(negedge ACLK);
        start = 1;
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge ACLK);
            #1;
            start = 0;
            if (M_AXI_RREADY && ar_addr_l == BASE + 32'h8) hit = 1;
        end
        check_eq("abort_reached", 32'(hit), 32'd1);
        #1 ARESET = 1;
        #1;
        check_all_zero("abort");
        exp_wr_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge ACLK);
        #2 ARESET = 0;
        busy_cnt = 0;
        repeat (6) begin
            @(posedge ACLK);
            #1;
            if (busy) busy_cnt++;
        end
        check_eq("no_resume", 32'(busy_cnt), 32'd0);
        run_pass("post_rst", 4 * N + 2, 0);

        // start held high across two back-to-back passes
        push_pass();
        push_pass();
        @(negedge ACLK);
        start = 1;
        cyc = 1; dones = 0; d1 = 0; d2 = 0;
        for (int c = 0; c < 4000 && dones < 2; c++) begin
            @(posedge ACLK);
            #1;
            cyc++;
            if (dones == 1 && cyc == d1 + 1) check_eq("held_gap_idle", 32'(busy), 32'd0);
            if (done) begin
                dones++;
                if (dones == 1) d1 = cyc;
                else begin d2 = cyc; start = 0; end
            end
        end
        check_eq("held_dones", 32'(dones), 32'd2);
        check_eq("held_first", 32'(d1), 32'(4 * N + 2));
        check_eq("held_second", 32'(d2), 32'(2 * (4 * N + 2)));
        busy_cnt = 0;
        repeat (5) begin
            @(posedge ACLK);
            #1;
            if (busy) busy_cnt++;
        end
        check_eq("held_stop", 32'(busy_cnt), 32'd0);
        check_eq("held_sb_empty", 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);

        check_eq("protocol", 32'(proto_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
